// File: rtl/heartbeat_emitter_if.sv
// Signal bundle between a heartbeat emitter and the logic around it: control inputs from the
// system side, and watchdog drive plus statistics back out.
interface heartbeat_emitter_if;
  logic        I_ENABLE;
  logic        I_ALIVE_TICK;
  logic        I_SYSTEM_RESET;
  logic        I_MISS_CLEAR;
  logic        O_HEARTBEAT_START;
  logic        O_HEARTBEAT_RESET;
  logic [15:0] O_BEAT_COUNT;
  logic [7:0]  O_MISS_COUNT;
  logic        O_MISSED;

  modport slave (
    input  I_ENABLE, I_ALIVE_TICK, I_SYSTEM_RESET, I_MISS_CLEAR,
    output O_HEARTBEAT_START, O_HEARTBEAT_RESET, O_BEAT_COUNT, O_MISS_COUNT, O_MISSED
  );

  modport master (
    output I_ENABLE, I_ALIVE_TICK, I_SYSTEM_RESET, I_MISS_CLEAR,
    input  O_HEARTBEAT_START, O_HEARTBEAT_RESET, O_BEAT_COUNT, O_MISS_COUNT, O_MISSED
  );
endinterface

// File: rtl/heartbeat_emitter.sv
// Watchdog heartbeat generator: one pulse per window in which the processor showed activity.
// Define HEARTBEAT_AUTO_TICK_EN to treat every window as alive (bring-up mode).
module heartbeat_emitter #(
  parameter int unsigned PERIOD_CYCLES  = 25_000_000,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned HOLDOFF_CYCLES = 10000
) (
  input logic               clk,
  input logic               rst,
  heartbeat_emitter_if.slave hb
);

  localparam logic [31:0] WIN_LAST   = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST  = (HOLDOFF_CYCLES == 0) ? 32'd0 : 32'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {OFF, RUN, PULSE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q, win_d;
  logic        tick_seen_q, tick_seen_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic [15:0] beat_q, beat_d;
  logic [7:0]  miss_q, miss_d;
  logic        missed_q, missed_d;
  logic        wrap;
  logic        tick_eff;

  assign wrap = (win_q == WIN_LAST);

`ifdef HEARTBEAT_AUTO_TICK_EN
  assign tick_eff = 1'b1;
`else
  // A tick landing in the wrap cycle still belongs to the window that is ending.
  assign tick_eff = tick_seen_q | hb.I_ALIVE_TICK;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OFF;
      win_q       <= '0;
      tick_seen_q <= 1'b0;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      beat_q      <= '0;
      miss_q      <= '0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      tick_seen_q <= tick_seen_d;
      pcnt_q      <= pcnt_d;
      hcnt_q      <= hcnt_d;
      beat_q      <= beat_d;
      miss_q      <= miss_d;
      missed_q    <= missed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    tick_seen_d = tick_seen_q;
    pcnt_d      = pcnt_q;
    hcnt_d      = hcnt_q;
    beat_d      = beat_q;
    miss_d      = miss_q;
    missed_d    = missed_q;

    if (hb.I_MISS_CLEAR) missed_d = 1'b0;

    case (state_q)
      OFF: begin
        if (hb.I_ENABLE) begin
          state_d     = RUN;
          win_d       = '0;
          tick_seen_d = 1'b0;
        end
      end
      RUN, PULSE: begin
        if (!hb.I_ENABLE) begin
          state_d = OFF;
        end else if (hb.I_SYSTEM_RESET) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end else begin
          win_d       = wrap ? 32'd0 : win_q + 32'd1;
          tick_seen_d = wrap ? 1'b0 : tick_eff;
          if (state_q == PULSE) begin
            if (pcnt_q == PULSE_LAST) state_d = RUN;
            else                      pcnt_d  = pcnt_q + 32'd1;
          end
          if (wrap) begin
            if (tick_eff) begin
              state_d = PULSE;
              pcnt_d  = '0;
              beat_d  = beat_q + 16'd1;
            end else begin
              miss_d   = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
              missed_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (!hb.I_ENABLE) begin
          state_d = OFF;
        end else if (hb.I_SYSTEM_RESET) begin
          hcnt_d = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d     = RUN;
          win_d       = '0;
          tick_seen_d = 1'b0;
        end else begin
          hcnt_d = hcnt_q + 32'd1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Watchdog drive comes straight from the state flops so no input reaches it combinationally.
  assign hb.O_HEARTBEAT_START = (state_q != OFF);
  assign hb.O_HEARTBEAT_RESET = (state_q == PULSE);
  assign hb.O_BEAT_COUNT      = beat_q;
  assign hb.O_MISS_COUNT      = miss_q;
  assign hb.O_MISSED          = missed_q;

endmodule

// File: tb/tb_heartbeat_emitter.sv
// Directed bench for heartbeat_emitter with a 100-cycle window, 4-cycle pulse, 20-cycle holdoff.
module tb_heartbeat_emitter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_starts;
  int   pulse_hi;
  int   starts[$];
  logic prev_pulse;

  heartbeat_emitter_if hb ();

  heartbeat_emitter #(
    .PERIOD_CYCLES (100),
    .PULSE_CYCLES  (4),
    .HOLDOFF_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hb (hb)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (hb.O_HEARTBEAT_RESET) pulse_hi++;
      if (hb.O_HEARTBEAT_RESET && !prev_pulse) begin
        n_starts++;
        starts.push_back(cyc);
      end
      prev_pulse = hb.O_HEARTBEAT_RESET;
    end
  endtask

  task automatic clr_mon();
    n_starts   = 0;
    pulse_hi   = 0;
    starts     = {};
    prev_pulse = hb.O_HEARTBEAT_RESET;
  endtask

  task automatic do_reset();
    hb.I_ENABLE       = 1'b0;
    hb.I_ALIVE_TICK   = 1'b0;
    hb.I_SYSTEM_RESET = 1'b0;
    hb.I_MISS_CLEAR   = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    clr_mon();
  endtask

  // Enable is sampled at the next edge; the window counter reads 0 afterwards.
  task automatic enable_now();
    hb.I_ENABLE = 1'b1;
    step(1);
  endtask

  task automatic tick_once();
    hb.I_ALIVE_TICK = 1'b1;
    step(1);
    hb.I_ALIVE_TICK = 1'b0;
  endtask

  task automatic test_reset();
    hb.I_ENABLE = 1'b1; hb.I_ALIVE_TICK = 1'b1; hb.I_SYSTEM_RESET = 1'b0; hb.I_MISS_CLEAR = 1'b0;
    rst = 1'b1;
    step(3);
    checks++;
    if ({hb.O_HEARTBEAT_START, hb.O_HEARTBEAT_RESET, hb.O_MISSED} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {hb.O_HEARTBEAT_START, hb.O_HEARTBEAT_RESET, hb.O_MISSED});
    end
    checks++;
    if (hb.O_BEAT_COUNT !== 16'd0 || hb.O_MISS_COUNT !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts got beat=%0d miss=%0d exp 0/0", hb.O_BEAT_COUNT, hb.O_MISS_COUNT);
    end
    rst = 1'b0;
    hb.I_ALIVE_TICK = 1'b0;
    hb.I_ENABLE = 1'b0;
    step(1);
  endtask

  task automatic test_beats();
    do_reset();
    enable_now();
    checks++;
    if (hb.O_HEARTBEAT_START !== 1'b1) begin
      failures++;
      $display("FAIL beats_start got=%b exp=1", hb.O_HEARTBEAT_START);
    end
    for (int w = 0; w < 5; w++) begin
      step(50);
      tick_once();
      step(49);
    end
    step(4);
    checks++;
    if (n_starts !== 5 || pulse_hi !== 20) begin
      failures++;
      $display("FAIL beats_pulses got starts=%0d hi=%0d exp 5/20", n_starts, pulse_hi);
    end
    checks++;
    if (starts.size() == 5 && (starts[1] - starts[0] != 100 || starts[4] - starts[3] != 100)) begin
      failures++;
      $display("FAIL beats_spacing got %0d,%0d exp 100,100", starts[1] - starts[0], starts[4] - starts[3]);
    end
    checks++;
    if (hb.O_BEAT_COUNT !== 16'd5 || hb.O_MISSED !== 1'b0) begin
      failures++;
      $display("FAIL beats_count got beat=%0d missed=%b exp 5/0", hb.O_BEAT_COUNT, hb.O_MISSED);
    end
  endtask

  task automatic test_miss();
    do_reset();
    enable_now();
    step(300);
    checks++;
    if (hb.O_MISS_COUNT !== 8'd3 || hb.O_MISSED !== 1'b1 || n_starts !== 0) begin
      failures++;
      $display("FAIL miss_count got miss=%0d missed=%b starts=%0d exp 3/1/0", hb.O_MISS_COUNT, hb.O_MISSED, n_starts);
    end
    hb.I_MISS_CLEAR = 1'b1;
    step(1);
    hb.I_MISS_CLEAR = 1'b0;
    checks++;
    if (hb.O_MISSED !== 1'b0 || hb.O_MISS_COUNT !== 8'd3) begin
      failures++;
      $display("FAIL miss_clear got missed=%b miss=%0d exp 0/3", hb.O_MISSED, hb.O_MISS_COUNT);
    end
    step(98);
    hb.I_MISS_CLEAR = 1'b1;
    step(1);
    hb.I_MISS_CLEAR = 1'b0;
    checks++;
    if (hb.O_MISSED !== 1'b1 || hb.O_MISS_COUNT !== 8'd4) begin
      failures++;
      $display("FAIL miss_set_wins got missed=%b miss=%0d exp 1/4", hb.O_MISSED, hb.O_MISS_COUNT);
    end
  endtask

  task automatic test_tick_at_wrap();
    do_reset();
    enable_now();
    step(99);
    tick_once();
    checks++;
    if (hb.O_HEARTBEAT_RESET !== 1'b1 || hb.O_BEAT_COUNT !== 16'd1) begin
      failures++;
      $display("FAIL wrap_tick got reset=%b beat=%0d exp 1/1", hb.O_HEARTBEAT_RESET, hb.O_BEAT_COUNT);
    end
    step(100);
    checks++;
    if (hb.O_MISS_COUNT !== 8'd1 || hb.O_MISSED !== 1'b1 || n_starts !== 1) begin
      failures++;
      $display("FAIL wrap_next_miss got miss=%0d missed=%b starts=%0d exp 1/1/1", hb.O_MISS_COUNT, hb.O_MISSED, n_starts);
    end
  endtask

  task automatic test_sysreset();
    do_reset();
    enable_now();
    step(50);
    tick_once();
    step(49);
    hb.I_SYSTEM_RESET = 1'b1;
    step(1);
    checks++;
    if (hb.O_HEARTBEAT_RESET !== 1'b0 || hb.O_HEARTBEAT_START !== 1'b1) begin
      failures++;
      $display("FAIL sysrst_abort got reset=%b start=%b exp 0/1", hb.O_HEARTBEAT_RESET, hb.O_HEARTBEAT_START);
    end
    step(49);
    hb.I_SYSTEM_RESET = 1'b0;
    step(20);
    checks++;
    if (hb.O_BEAT_COUNT !== 16'd1 || pulse_hi !== 1 || hb.O_MISS_COUNT !== 8'd0) begin
      failures++;
      $display("FAIL sysrst_frozen got beat=%0d hi=%0d miss=%0d exp 1/1/0", hb.O_BEAT_COUNT, pulse_hi, hb.O_MISS_COUNT);
    end
    step(50);
    tick_once();
    step(48);
    checks++;
    if (hb.O_HEARTBEAT_RESET !== 1'b0) begin
      failures++;
      $display("FAIL sysrst_early got reset=%b exp 0", hb.O_HEARTBEAT_RESET);
    end
    step(1);
    checks++;
    if (hb.O_HEARTBEAT_RESET !== 1'b1 || hb.O_BEAT_COUNT !== 16'd2) begin
      failures++;
      $display("FAIL sysrst_rerun got reset=%b beat=%0d exp 1/2", hb.O_HEARTBEAT_RESET, hb.O_BEAT_COUNT);
    end
  endtask

  task automatic test_disable();
    do_reset();
    enable_now();
    step(100);
    step(50);
    tick_once();
    step(49);
    step(1);
    hb.I_ENABLE = 1'b0;
    step(1);
    checks++;
    if (hb.O_HEARTBEAT_START !== 1'b0 || hb.O_HEARTBEAT_RESET !== 1'b0) begin
      failures++;
      $display("FAIL dis_outputs got start=%b reset=%b exp 0/0", hb.O_HEARTBEAT_START, hb.O_HEARTBEAT_RESET);
    end
    checks++;
    if (hb.O_BEAT_COUNT !== 16'd1 || hb.O_MISS_COUNT !== 8'd1 || hb.O_MISSED !== 1'b1) begin
      failures++;
      $display("FAIL dis_hold got beat=%0d miss=%0d missed=%b exp 1/1/1", hb.O_BEAT_COUNT, hb.O_MISS_COUNT, hb.O_MISSED);
    end
    step(5);
    enable_now();
    step(50);
    tick_once();
    step(48);
    checks++;
    if (hb.O_HEARTBEAT_RESET !== 1'b0) begin
      failures++;
      $display("FAIL dis_early got reset=%b exp 0", hb.O_HEARTBEAT_RESET);
    end
    step(1);
    checks++;
    if (hb.O_HEARTBEAT_RESET !== 1'b1 || hb.O_BEAT_COUNT !== 16'd2) begin
      failures++;
      $display("FAIL dis_restart got reset=%b beat=%0d exp 1/2", hb.O_HEARTBEAT_RESET, hb.O_BEAT_COUNT);
    end
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (hb.O_HEARTBEAT_RESET !== 1'b0 || hb.O_BEAT_COUNT !== 16'd0) begin
      failures++;
      $display("FAIL rst_midpulse got reset=%b beat=%0d exp 0/0", hb.O_HEARTBEAT_RESET, hb.O_BEAT_COUNT);
    end
  endtask

  task automatic test_auto_tick();
    do_reset();
    enable_now();
    step(300);
    checks++;
    if (n_starts !== 3 || hb.O_BEAT_COUNT !== 16'd3) begin
      failures++;
      $display("FAIL auto_pulses got starts=%0d beat=%0d exp 3/3", n_starts, hb.O_BEAT_COUNT);
    end
    checks++;
    if (hb.O_MISS_COUNT !== 8'd0 || hb.O_MISSED !== 1'b0) begin
      failures++;
      $display("FAIL auto_nomiss got miss=%0d missed=%b exp 0/0", hb.O_MISS_COUNT, hb.O_MISSED);
    end
  endtask

  initial begin
    prev_pulse = 1'b0;
    n_starts   = 0;
    pulse_hi   = 0;
    test_reset();
`ifdef HEARTBEAT_AUTO_TICK_EN
    test_auto_tick();
`else
    test_beats();
    test_miss();
    test_tick_at_wrap();
    test_sysreset();
    test_disable();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
